scurve_sweep_engine: RTL
========================

Name: scurve_sweep_engine

Overview:
Parametrised successor to the S-curve test controller. Sweeps the 10-bit threshold DAC over a programmable range, in either direction, for one channel or all channels. At each point it requests an ASIC slow-control reload, measures triggers over a fixed number of external-clock periods, and streams tagged result words into the USB data FIFO. Adds descending sweeps, a selectable discriminator, two counting modes, counter saturation and a clean abort.

Parameters:
CHN_NUM, 64, number of channels swept in all-channel mode
CHN_W, 6, channel index width (≤12)
DAC_W, 10, threshold DAC width (≤12)
CNT_W, 16, window and trigger counter width (≤16)
NUM_DISCRI, 3, number of discriminator trigger inputs (≤4)

Ports:
Clk  in  1  system clock; sole clock
reset  in  1  synchronous, active-high reset
Test_Start  in  1  level; rising edge starts a sweep
Abort  in  1  level; stops the sweep immediately
Single_or_AllChn  in  1  1 = single channel, 0 = channels 0..CHN_NUM-1
SingleTest_Chn  in  CHN_W  channel used in single mode
StartDac  in  DAC_W  first DAC code
EndDac  in  DAC_W  last DAC code
DacStep  in  DAC_W  step magnitude; 0 is treated as 1
Window_Max  in  CNT_W  external-clock periods per point; 0 is treated as 1
Count_Mode  in  1  0 = trigger efficiency (≤1 hit per Ext_Clk period), 1 = count every hit
Discri_Sel  in  2  index of the counted trigger input; values ≥NUM_DISCRI select input 0
Ext_Clk_In  in  1  asynchronous external clock
Trigger_In  in  NUM_DISCRI  asynchronous, active-low discriminator outputs
Cfg_Load  out  1  one-cycle request to reload slow control
Cfg_Chn  out  CHN_W  channel under test
Cfg_Dac  out  DAC_W  current DAC code
Cfg_Done  in  1  pulse: slow-control reload complete
Data_Out  out  16  result word
Data_Wr_En  out  1  FIFO write strobe
Data_Fifo_Full  in  1  FIFO full
Busy  out  1  sweep in progress
Test_Done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset also clears the synchronisers and edge-detect history.
- Ext_Clk_In and each Trigger_In pass through a 2-flop synchroniser, then a 1-flop edge detector. Rising Ext_Clk edge = ECE. Falling edge of the selected trigger = TRG. Detection latency is 3 Clk cycles.
- Start: a rising edge of Test_Start in IDLE latches every configuration input and sets Busy on the next cycle. Test_Start edges while Busy are ignored.
- Direction: ascending if StartDac ≤ EndDac, otherwise descending.
- Next-DAC computation uses DAC_W+1-bit arithmetic. The current point is the last point when the next code would pass EndDac or leave the range 0..2^DAC_W-1. EndDac is included only if it is reached exactly.
- Loop order: channel is the outer loop, DAC the inner loop.
- FSM states: IDLE → LOAD → WAIT_CFG → ALIGN → COUNT → WR_CHN → WR_DAC → WR_CNT → (LOAD | NEXT_CHN → LOAD | WR_END) → DONE → IDLE.
- LOAD: drive Cfg_Chn and Cfg_Dac; pulse Cfg_Load for one cycle.
- WAIT_CFG: wait for Cfg_Done; there is no timeout. A Cfg_Done seen in any other state is ignored.
- ALIGN: the first ECE opens the measurement window; clear the window and hit counters.
- COUNT: each ECE increments the window counter. The window closes on the ECE that brings it to Window_Max.
  - Mode 1: every TRG increments the hit counter.
  - Mode 0: at most one TRG is counted per ECE-to-ECE period.
  - A TRG in the same cycle as the closing ECE is counted. A TRG in the same cycle as the opening ECE is not counted.
  - The hit counter saturates at all-ones.
- Result words, each CHN/DAC/CNT field zero-extended:
  - WR_CHN: {4'hC, channel on 12 bits}
  - WR_DAC: {4'hD, DAC on 12 bits}
  - WR_CNT: hit count on 16 bits
  - WR_END: 16'hFF45
- Write handshake: in a WR state, Data_Wr_En=1 for one cycle only when Data_Fifo_Full=0, and the FSM advances that same cycle. While full, Data_Out is held, Data_Wr_En=0, and the FSM stalls with no word lost or duplicated.
- DONE: pulse Test_Done for one cycle; Busy drops in that same cycle.
- Abort: takes priority over everything. Next cycle the FSM is in IDLE with Busy=0, Data_Wr_En=0, Cfg_Load=0, and no Test_Done or end word. Reset behaves the same mid-operation.

Test Plan:
- Single channel 5, Start=100, End=110, Step=5, Window_Max=4, Count_Mode=1, three trigger falling edges per Ext_Clk period → points 100/105/110; each point writes C005, D064/D069/D06E, 000C; then FF45 and one Test_Done pulse.
- Descending sweep Start=10, End=0, Step=4 → DAC words D00A, D006, D002 only; Start=1020, End=1023, Step=8 → single point D3FC.
- Count_Mode=0 with 3 hits per period, Window_Max=4 → count 0004. Count_Mode=1, CNT_W=4, 40 hits → 000F (saturated).
- All-channel mode, CHN_NUM=64, single DAC point → 64×3 words, channels C000..C03F in order, then FF45; Cfg_Load pulses 64 times.
- Assert Data_Fifo_Full for 20 cycles during WR_DAC → Data_Wr_En stays low and Data_Out is stable; on release the stream continues with no gap or duplicate in the word sequence.
- Abort asserted during COUNT, then Test_Start again → IDLE next cycle with no Test_Done; the restarted sweep produces a complete, correct stream. Test_Start edge while Busy → no effect.

Source files
------------

// File: rtl/scurve_sweep_engine_if.sv
// Slow-control reload and result-FIFO signals of the S-curve sweep engine.
// The engine is the master, the ASIC config block and USB FIFO the slave.
interface scurve_sweep_engine_if #(
    parameter int CHN_W = 6,
    parameter int DAC_W = 10
);
    logic             Cfg_Load;
    logic [CHN_W-1:0] Cfg_Chn;
    logic [DAC_W-1:0] Cfg_Dac;
    logic             Cfg_Done;
    logic [15:0]      Data_Out;
    logic             Data_Wr_En;
    logic             Data_Fifo_Full;

    modport master (
        output Cfg_Load, Cfg_Chn, Cfg_Dac, Data_Out, Data_Wr_En,
        input  Cfg_Done, Data_Fifo_Full
    );

    modport slave (
        input  Cfg_Load, Cfg_Chn, Cfg_Dac, Data_Out, Data_Wr_En,
        output Cfg_Done, Data_Fifo_Full
    );
endinterface

// File: rtl/scurve_sweep_engine.sv
// S-curve sweep engine: steps the threshold DAC per channel, counts
// discriminator hits over Ext_Clk windows and streams tagged results.
module scurve_sweep_engine #(
    parameter int CHN_NUM    = 64,
    parameter int CHN_W      = 6,
    parameter int DAC_W      = 10,
    parameter int CNT_W      = 16,
    parameter int NUM_DISCRI = 3
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  Test_Start,
    input  logic                  Abort,
    input  logic                  Single_or_AllChn,
    input  logic [CHN_W-1:0]      SingleTest_Chn,
    input  logic [DAC_W-1:0]      StartDac,
    input  logic [DAC_W-1:0]      EndDac,
    input  logic [DAC_W-1:0]      DacStep,
    input  logic [CNT_W-1:0]      Window_Max,
    input  logic                  Count_Mode,
    input  logic [1:0]            Discri_Sel,
    input  logic                  Ext_Clk_In,
    input  logic [NUM_DISCRI-1:0] Trigger_In,
    scurve_sweep_engine_if.master bus,
    output logic                  Busy,
    output logic                  Test_Done
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WAIT_CFG, S_ALIGN, S_COUNT,
        S_WR_CHN, S_WR_DAC, S_WR_CNT, S_NEXT_CHN, S_WR_END, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                  ext_s1, ext_s2, ext_d;
    logic [NUM_DISCRI-1:0] trg_s1, trg_s2, trg_d;
    logic [NUM_DISCRI-1:0] trg_fall;
    logic                  start_d;
    logic                  start_rise, ece, trg;

    logic                  single_q, mode_q, desc_q;
    logic [1:0]            sel_q;
    logic [CHN_W-1:0]      chn_q;
    logic [DAC_W-1:0]      dac_q, start_q, end_q, step_q;
    logic [CNT_W-1:0]      win_max_q, win_cnt, hit_cnt;
    logic                  hit_flag;

    logic [DAC_W:0]        dac_nxt;
    logic                  last_dac, last_chn, close, full, wr_state;
    logic [11:0]           chn12, dac12;

    assign start_rise = Test_Start & ~start_d;
    assign ece        = ext_s2 & ~ext_d;
    assign trg_fall   = trg_d & ~trg_s2;
    assign full       = bus.Data_Fifo_Full;

    always_comb begin
        trg = trg_fall[0];
        for (int i = 1; i < NUM_DISCRI; i++)
            if (int'(sel_q) == i) trg = trg_fall[i];
    end

    // One extra bit catches wrap past either end of the DAC range
    assign dac_nxt = desc_q ? {1'b0, dac_q} - {1'b0, step_q}
                            : {1'b0, dac_q} + {1'b0, step_q};
    assign last_dac = dac_nxt[DAC_W] |
                      (desc_q ? (dac_nxt[DAC_W-1:0] < end_q)
                              : (dac_nxt[DAC_W-1:0] > end_q));
    assign last_chn = single_q | (chn_q == CHN_W'(CHN_NUM - 1));
    assign close    = ece & ((win_cnt + CNT_W'(1)) == win_max_q);
    assign chn12    = 12'(chn_q);
    assign dac12    = 12'(dac_q);
    assign wr_state = (state == S_WR_CHN) | (state == S_WR_DAC) |
                      (state == S_WR_CNT) | (state == S_WR_END);

    always_ff @(posedge Clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start_rise) state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_WAIT_CFG;
            S_WAIT_CFG: if (bus.Cfg_Done) state_nxt = S_ALIGN;
            S_ALIGN:    if (ece) state_nxt = S_COUNT;
            S_COUNT:    if (close) state_nxt = S_WR_CHN;
            S_WR_CHN:   if (!full) state_nxt = S_WR_DAC;
            S_WR_DAC:   if (!full) state_nxt = S_WR_CNT;
            S_WR_CNT: begin
                if (!full) begin
                    if (!last_dac)      state_nxt = S_LOAD;
                    else if (!last_chn) state_nxt = S_NEXT_CHN;
                    else                state_nxt = S_WR_END;
                end
            end
            S_NEXT_CHN: state_nxt = S_LOAD;
            S_WR_END:   if (!full) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (Abort) state_nxt = S_IDLE;
    end

    always_comb begin
        bus.Cfg_Load   = (state == S_LOAD) & ~Abort;
        bus.Cfg_Chn    = chn_q;
        bus.Cfg_Dac    = dac_q;
        bus.Data_Wr_En = wr_state & ~full & ~Abort;
        Busy           = (state != S_IDLE) & (state != S_DONE);
        Test_Done      = (state == S_DONE) & ~Abort;
        unique case (state)
            S_WR_CHN: bus.Data_Out = {4'hC, chn12};
            S_WR_DAC: bus.Data_Out = {4'hD, dac12};
            S_WR_CNT: bus.Data_Out = 16'(hit_cnt);
            S_WR_END: bus.Data_Out = 16'hFF45;
            default:  bus.Data_Out = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            ext_s1    <= 1'b0;
            ext_s2    <= 1'b0;
            ext_d     <= 1'b0;
            trg_s1    <= '0;
            trg_s2    <= '0;
            trg_d     <= '0;
            start_d   <= 1'b0;
            single_q  <= 1'b0;
            mode_q    <= 1'b0;
            desc_q    <= 1'b0;
            sel_q     <= '0;
            chn_q     <= '0;
            dac_q     <= '0;
            start_q   <= '0;
            end_q     <= '0;
            step_q    <= '0;
            win_max_q <= '0;
            win_cnt   <= '0;
            hit_cnt   <= '0;
            hit_flag  <= 1'b0;
        end else begin
            ext_s1  <= Ext_Clk_In;
            ext_s2  <= ext_s1;
            ext_d   <= ext_s2;
            trg_s1  <= Trigger_In;
            trg_s2  <= trg_s1;
            trg_d   <= trg_s2;
            start_d <= Test_Start;

            if (state == S_IDLE && start_rise) begin
                single_q  <= Single_or_AllChn;
                mode_q    <= Count_Mode;
                sel_q     <= Discri_Sel;
                desc_q    <= StartDac > EndDac;
                start_q   <= StartDac;
                end_q     <= EndDac;
                step_q    <= (DacStep == '0) ? DAC_W'(1) : DacStep;
                win_max_q <= (Window_Max == '0) ? CNT_W'(1) : Window_Max;
                dac_q     <= StartDac;
                chn_q     <= Single_or_AllChn ? SingleTest_Chn : '0;
            end

            if (state == S_ALIGN) begin
                win_cnt  <= '0;
                hit_cnt  <= '0;
                hit_flag <= 1'b0;
            end

            // A hit coinciding with the closing edge still belongs to the window
            if (state == S_COUNT) begin
                if (ece) win_cnt <= win_cnt + CNT_W'(1);
                if (trg && (mode_q || !hit_flag) && hit_cnt != '1)
                    hit_cnt <= hit_cnt + CNT_W'(1);
                if (ece)      hit_flag <= 1'b0;
                else if (trg) hit_flag <= 1'b1;
            end

            if (state == S_WR_CNT && !full && !last_dac)
                dac_q <= dac_nxt[DAC_W-1:0];

            if (state == S_NEXT_CHN) begin
                chn_q <= chn_q + CHN_W'(1);
                dac_q <= start_q;
            end
        end
    end

endmodule
